fb_writer: RTL and testbench

FB_WRITER -- requirements
Module: fb_writer

---
 rtl/fb_writer_pkg.sv | 25 ++
 rtl/fb_writer_sync_fifo.sv | 58 +++++
 rtl/fb_writer.sv | 179 +++++++++++++++++
 tb/tb_fb_writer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_writer_pkg.sv
// Shared definitions for the frame-buffer writer: FSM encoding, screen and
// clear-burst geometry, MCB command codes and the byte-lane mask helper.
package fb_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PIX_DATA = 3'd1,
    ST_PIX_CMD  = 3'd2,
    ST_CLR_DATA = 3'd3,
    ST_CLR_CMD  = 3'd4
  } fb_state_t;

  localparam int SCREEN_W        = 256;
  localparam int SCREEN_H        = 192;
  localparam int CLR_BURST_WORDS = 16;
  localparam int CLR_BURSTS      = 768;

  localparam logic [2:0] MCB_CMD_WRITE = 3'b000;

  // Write mask for a single-byte store: every lane masked except the target.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    lane_mask = ~(4'b0001 << lane);
  endfunction

endpackage

// File: rtl/fb_writer_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags; the head entry is read
// straight out of the storage registers so it is valid whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nx;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  // Occupancy after this cycle's push/pop, used to register the flags.
  always_comb begin
    count_nx = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      full  <= (count_nx == (AW+1)'(DEPTH));
      empty <= (count_nx == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fb_writer.sv
// Frame-buffer writer: queues single-pixel writes and whole-screen clears and
// turns them into MCB write-data pushes followed by their write commands.
module fb_writer
  import fb_writer_pkg::*;
#(
  parameter logic [29:0] FB_BASE    = 30'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_x,
  input  logic [7:0]  pix_y,
  input  logic [7:0]  pix_color,
  input  logic        clear_req,
  input  logic [7:0]  clear_color,
  output logic        busy,
  output logic [7:0]  drop_count,
  input  logic        mem_calib_done,
  input  logic        mem_cmd_full,
  input  logic        mem_wr_full,
  input  logic        mem_wr_underrun,
  input  logic        mem_wr_error,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_mask
);

  fb_state_t   state;
  fb_state_t   state_nx;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic [37:0] fifo_din;
  logic [37:0] fifo_dout;
  logic [29:0] pix_addr;
  logic        pix_accept;
  logic        pix_in_range;
  logic        clr_pending;
  logic [7:0]  clr_color;
  logic [3:0]  word_cnt;
  logic [9:0]  burst_cnt;
  logic        last_word;
  logic        last_burst;
  logic        unused_status;

  // Underrun/error are status for the surrounding system, not flow control.
  assign unused_status = mem_wr_underrun | mem_wr_error;

  assign pix_ready    = !rst && !fifo_full && !clr_pending && mem_calib_done;
  assign pix_accept   = pix_valid && pix_ready;
  assign pix_in_range = (pix_y < 8'(SCREEN_H));
  assign fifo_push    = pix_accept && pix_in_range;
  assign pix_addr     = FB_BASE + {14'd0, pix_y, pix_x};
  assign fifo_din     = {pix_addr, pix_color};

  assign last_word  = (word_cnt == 4'(CLR_BURST_WORDS - 1));
  assign last_burst = (burst_cnt == 10'(CLR_BURSTS - 1));
  assign busy       = !fifo_empty || clr_pending || (state != ST_IDLE);

  sync_fifo #(
    .WIDTH(38),
    .DEPTH(FIFO_DEPTH)
  ) u_pix_fifo (
    .clk  (clk),
    .rst  (rst),
    .wr_en(fifo_push),
    .din  (fifo_din),
    .rd_en(fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and MCB strobes; data always goes out before its command.
  always_comb begin
    state_nx   = state;
    mem_wr_en  = 1'b0;
    mem_cmd_en = 1'b0;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_calib_done) begin
          if (!fifo_empty)      state_nx = ST_PIX_DATA;
          else if (clr_pending) state_nx = ST_CLR_DATA;
        end
      end
      ST_PIX_DATA: begin
        if (!mem_wr_full) begin
          mem_wr_en = 1'b1;
          fifo_pop  = 1'b1;
          state_nx  = ST_PIX_CMD;
        end
      end
      ST_PIX_CMD: begin
        if (!mem_cmd_full) begin
          mem_cmd_en = 1'b1;
          state_nx   = ST_IDLE;
        end
      end
      ST_CLR_DATA: begin
        if (!mem_wr_full) begin
          mem_wr_en = 1'b1;
          if (last_word) state_nx = ST_CLR_CMD;
        end
      end
      ST_CLR_CMD: begin
        if (!mem_cmd_full) begin
          mem_cmd_en = 1'b1;
          state_nx   = last_burst ? ST_IDLE : ST_CLR_DATA;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Clear bookkeeping, burst/word counters and the saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_pending <= 1'b0;
      word_cnt    <= '0;
      burst_cnt   <= '0;
      drop_count  <= '0;
    end else begin
      if (clear_req)
        clr_pending <= 1'b1;
      else if (state == ST_CLR_CMD && mem_cmd_en && last_burst)
        clr_pending <= 1'b0;
      if (state == ST_CLR_DATA && mem_wr_en)
        word_cnt <= word_cnt + 4'd1;
      if (state == ST_CLR_CMD && mem_cmd_en)
        burst_cnt <= last_burst ? '0 : burst_cnt + 10'd1;
      if (pix_accept && !pix_in_range && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  // Latest requested fill colour; a repeat request just updates it.
  always_ff @(posedge clk) begin
    if (clear_req) clr_color <= clear_color;
  end

  // Registered MCB payload, loaded ahead of the cycle it is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr_data       <= '0;
      mem_wr_mask       <= '0;
      mem_cmd_byte_addr <= '0;
      mem_cmd_bl        <= '0;
      mem_cmd_instr     <= '0;
    end else if (state == ST_IDLE && state_nx == ST_PIX_DATA) begin
      mem_wr_data       <= {4{fifo_dout[7:0]}};
      mem_wr_mask       <= lane_mask(fifo_dout[9:8]);
      mem_cmd_byte_addr <= {fifo_dout[37:10], 2'b00};
      mem_cmd_bl        <= 6'd0;
      mem_cmd_instr     <= MCB_CMD_WRITE;
    end else if (state != ST_CLR_DATA && state_nx == ST_CLR_DATA) begin
      mem_wr_data <= {4{clr_color}};
      mem_wr_mask <= 4'b0000;
    end else if (state == ST_CLR_DATA && state_nx == ST_CLR_CMD) begin
      mem_cmd_byte_addr <= FB_BASE + {14'd0, burst_cnt, 6'd0};
      mem_cmd_bl        <= 6'(CLR_BURST_WORDS - 1);
      mem_cmd_instr     <= MCB_CMD_WRITE;
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: single pixels, lane masks, drops, FIFO
// back-pressure, full-screen clears and reset in the middle of a clear.
module tb_fb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [7:0]  pix_color;
  logic        clear_req;
  logic [7:0]  clear_color;
  logic        busy;
  logic [7:0]  drop_count;
  logic        mem_calib_done;
  logic        mem_cmd_full;
  logic        mem_wr_full;
  logic        mem_wr_underrun;
  logic        mem_wr_error;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_mask;

  always #5 clk = ~clk;

  fb_writer dut (
    .clk              (clk),
    .rst              (rst),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_x            (pix_x),
    .pix_y            (pix_y),
    .pix_color        (pix_color),
    .clear_req        (clear_req),
    .clear_color      (clear_color),
    .busy             (busy),
    .drop_count       (drop_count),
    .mem_calib_done   (mem_calib_done),
    .mem_cmd_full     (mem_cmd_full),
    .mem_wr_full      (mem_wr_full),
    .mem_wr_underrun  (mem_wr_underrun),
    .mem_wr_error     (mem_wr_error),
    .mem_cmd_en       (mem_cmd_en),
    .mem_cmd_instr    (mem_cmd_instr),
    .mem_cmd_bl       (mem_cmd_bl),
    .mem_cmd_byte_addr(mem_cmd_byte_addr),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_data      (mem_wr_data),
    .mem_wr_mask      (mem_wr_mask)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Transaction recorder for the MCB side.
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_mask_q[$];
  int          wr_cyc_q[$];
  logic [29:0] cmd_addr_q[$];
  logic [5:0]  cmd_bl_q[$];
  logic [2:0]  cmd_instr_q[$];
  int          cmd_cyc_q[$];
  int          words_q[$];
  int          words_since = 0;
  int          overlap = 0;

  always @(negedge clk) begin
    if (mem_wr_en && mem_cmd_en) overlap++;
    if (mem_wr_en) begin
      wr_data_q.push_back(mem_wr_data);
      wr_mask_q.push_back(mem_wr_mask);
      wr_cyc_q.push_back(cyc);
      words_since++;
    end
    if (mem_cmd_en) begin
      cmd_addr_q.push_back(mem_cmd_byte_addr);
      cmd_bl_q.push_back(mem_cmd_bl);
      cmd_instr_q.push_back(mem_cmd_instr);
      cmd_cyc_q.push_back(cyc);
      words_q.push_back(words_since);
      words_since = 0;
    end
  end

  task automatic mon_clear();
    wr_data_q.delete(); wr_mask_q.delete(); wr_cyc_q.delete();
    cmd_addr_q.delete(); cmd_bl_q.delete(); cmd_instr_q.delete();
    cmd_cyc_q.delete(); words_q.delete();
    words_since = 0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one pixel; returns the cycle in which the handshake completed.
  task automatic send_pixel(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] c, output int acc_cyc);
    int t;
    t = 0;
    pix_x = x; pix_y = y; pix_color = c; pix_valid = 1'b1;
    while (!pix_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) check_val("pix_accept_timeout", t, 0);
    acc_cyc = cyc;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int low_cyc);
    int t;
    t = 0;
    while (busy && t < limit) begin
      tick();
      t++;
    end
    check_val("idle_timeout", busy, 0);
    low_cyc = cyc;
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  c;
    logic [29:0] a;
    logic [3:0]  m;
  } pv_t;

  pv_t vec[6];

  initial begin : main
    int acc;
    int lo;
    int bad;
    int t;
    logic [7:0]  c8;
    logic [29:0] ea;

    vec[0] = '{8'd0,   8'd0,   8'h01, 30'h0000, 4'b1110};
    vec[1] = '{8'd1,   8'd0,   8'h02, 30'h0000, 4'b1101};
    vec[2] = '{8'd2,   8'd0,   8'h03, 30'h0000, 4'b1011};
    vec[3] = '{8'd3,   8'd0,   8'h04, 30'h0000, 4'b0111};
    vec[4] = '{8'd255, 8'd191, 8'hFF, 30'hBFFC, 4'b0111};
    vec[5] = '{8'd130, 8'd100, 8'h5A, 30'h6480, 4'b1011};

    rst = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
    clear_req = 1'b0; clear_color = '0; mem_calib_done = 1'b1;
    mem_cmd_full = 1'b0; mem_wr_full = 1'b0; mem_wr_underrun = 1'b0; mem_wr_error = 1'b0;

    // Reset state
    tick(2);
    check_val("rst_pix_ready", pix_ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_wr_en", mem_wr_en, 0);
    check_val("rst_cmd_en", mem_cmd_en, 0);
    check_val("rst_drop", drop_count, 0);
    check_val("rst_wr_data", mem_wr_data, 0);
    check_val("rst_wr_mask", mem_wr_mask, 0);
    check_val("rst_cmd_addr", mem_cmd_byte_addr, 0);
    check_val("rst_cmd_bl", mem_cmd_bl, 0);
    check_val("rst_cmd_instr", mem_cmd_instr, 0);
    rst = 1'b0;
    tick();
    check_val("ready_after_rst", pix_ready, 1);
    mon_clear();

    // Single pixel with latency
    send_pixel(8'd5, 8'd3, 8'hE0, acc);
    wait_idle(50, lo);
    check_val("px1_wr_cnt", wr_data_q.size(), 1);
    check_val("px1_cmd_cnt", cmd_addr_q.size(), 1);
    check_val("px1_data", wr_data_q[0], 32'hE0E0E0E0);
    check_val("px1_mask", wr_mask_q[0], 4'b1101);
    check_val("px1_addr", cmd_addr_q[0], 30'h304);
    check_val("px1_bl", cmd_bl_q[0], 0);
    check_val("px1_instr", cmd_instr_q[0], 3'b000);
    check_val("px1_wr_lat", wr_cyc_q[0] - acc, 2);
    check_val("px1_cmd_lat", cmd_cyc_q[0] - acc, 3);
    mon_clear();

    // Lane masks and address corners
    foreach (vec[i]) send_pixel(vec[i].x, vec[i].y, vec[i].c, acc);
    wait_idle(100, lo);
    check_val("vec_wr_cnt", wr_data_q.size(), 6);
    check_val("vec_cmd_cnt", cmd_addr_q.size(), 6);
    foreach (vec[i]) begin
      c8 = vec[i].c;
      check_val($sformatf("vec%0d_data", i), wr_data_q[i], {c8, c8, c8, c8});
      check_val($sformatf("vec%0d_mask", i), wr_mask_q[i], vec[i].m);
      check_val($sformatf("vec%0d_addr", i), cmd_addr_q[i], vec[i].a);
    end
    mon_clear();

    // Out-of-range rows are dropped, count saturates
    send_pixel(8'd10, 8'd192, 8'h77, acc);
    tick(10);
    check_val("drop1_wr", wr_data_q.size(), 0);
    check_val("drop1_cmd", cmd_addr_q.size(), 0);
    check_val("drop1_cnt", drop_count, 1);
    check_val("drop1_busy", busy, 0);
    for (int i = 1; i < 300; i++) send_pixel(8'(i), 8'(192 + (i % 64)), 8'h11, acc);
    tick(5);
    check_val("drop300_cnt", drop_count, 255);
    check_val("drop300_wr", wr_data_q.size(), 0);
    mon_clear();

    // Back-pressure with command FIFO full
    mem_cmd_full = 1'b1;
    for (int i = 0; i < 5; i++) send_pixel(8'(10 + i), 8'd7, 8'(8'h10 + i), acc);
    check_val("bp_ready_low", pix_ready, 0);
    tick(5);
    check_val("bp_wr_cnt", wr_data_q.size(), 1);
    check_val("bp_cmd_cnt", cmd_addr_q.size(), 0);
    mem_cmd_full = 1'b0;
    wait_idle(100, lo);
    check_val("bp_wr_total", wr_data_q.size(), 5);
    check_val("bp_cmd_total", cmd_addr_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      c8 = 8'(8'h10 + i);
      ea = {14'd0, 8'd7, 8'(10 + i)} & ~30'h3;
      check_val($sformatf("bp%0d_data", i), wr_data_q[i], {c8, c8, c8, c8});
      check_val($sformatf("bp%0d_addr", i), cmd_addr_q[i], ea);
    end
    mon_clear();

    // Full-screen clear
    clear_req = 1'b1; clear_color = 8'h1C;
    tick();
    clear_req = 1'b0;
    check_val("clr_ready_low", pix_ready, 0);
    check_val("clr_busy", busy, 1);
    wait_idle(20000, lo);
    check_val("clr_wr_cnt", wr_data_q.size(), 12288);
    check_val("clr_cmd_cnt", cmd_addr_q.size(), 768);
    bad = 0;
    foreach (wr_data_q[i]) if (wr_data_q[i] !== 32'h1C1C1C1C || wr_mask_q[i] !== 4'b0000) bad++;
    check_val("clr_data_bad", bad, 0);
    bad = 0;
    foreach (cmd_addr_q[i])
      if (cmd_addr_q[i] !== 30'(i * 64) || cmd_bl_q[i] !== 6'd15 || words_q[i] != 16) bad++;
    check_val("clr_cmd_bad", bad, 0);
    check_val("clr_last_addr", (cmd_addr_q.size() > 0) ? cmd_addr_q[cmd_addr_q.size()-1] : 30'h3FFFFFFF, 30'hBFC0);
    check_val("clr_busy_fall", lo - ((cmd_cyc_q.size() > 0) ? cmd_cyc_q[cmd_cyc_q.size()-1] : 0), 1);
    mon_clear();

    // Clear with write FIFO stalling every other cycle and a repeat request
    clear_req = 1'b1; clear_color = 8'h55;
    tick();
    clear_req = 1'b0;
    t = 0;
    while (busy && t < 40000) begin
      mem_wr_full = (t % 2) == 0;
      clear_req = (t == 1000);
      tick();
      t++;
    end
    mem_wr_full = 1'b0;
    clear_req = 1'b0;
    check_val("tog_timeout", busy, 0);
    check_val("tog_wr_cnt", wr_data_q.size(), 12288);
    check_val("tog_cmd_cnt", cmd_addr_q.size(), 768);
    bad = 0;
    foreach (words_q[i]) if (words_q[i] != 16) bad++;
    check_val("tog_words_bad", bad, 0);
    bad = 0;
    foreach (wr_data_q[i]) if (wr_data_q[i] !== 32'h55555555) bad++;
    check_val("tog_data_bad", bad, 0);
    mon_clear();

    // Reset in the middle of a clear, then a normal pixel
    clear_req = 1'b1; clear_color = 8'h33;
    tick();
    clear_req = 1'b0;
    t = 0;
    while (cmd_addr_q.size() < 100 && t < 5000) begin
      tick();
      t++;
    end
    check_val("mid_reach_100", cmd_addr_q.size() >= 100, 1);
    rst = 1'b1;
    tick();
    check_val("mid_rst_wr_en", mem_wr_en, 0);
    check_val("mid_rst_cmd_en", mem_cmd_en, 0);
    check_val("mid_rst_wr_data", mem_wr_data, 0);
    check_val("mid_rst_cmd_addr", mem_cmd_byte_addr, 0);
    check_val("mid_rst_cmd_bl", mem_cmd_bl, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_ready", pix_ready, 0);
    check_val("mid_rst_drop", drop_count, 0);
    rst = 1'b0;
    mon_clear();
    tick(5);
    check_val("post_rst_quiet", wr_data_q.size(), 0);
    send_pixel(8'd10, 8'd20, 8'h3C, acc);
    wait_idle(50, lo);
    check_val("post_wr_cnt", wr_data_q.size(), 1);
    check_val("post_cmd_cnt", cmd_addr_q.size(), 1);
    check_val("post_data", wr_data_q[0], 32'h3C3C3C3C);
    check_val("post_mask", wr_mask_q[0], 4'b1011);
    check_val("post_addr", cmd_addr_q[0], 30'h1408);

    check_val("no_wr_cmd_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
